// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave bank of NUM_REGS byte-strobed control registers plus a read-only status word.
// Define AXIL_REG_SHADOW_EN to stage writes in shadow registers that a COMMIT write publishes atomically.
module axil_reg_bank #(
  parameter int          NUM_REGS   = 4,
  parameter int          REG_WIDTH  = 8,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_VAL  = 32'h0
) (
  input  logic                          aclk,
  input  logic                          arst,
  input  logic [ADDR_WIDTH-1:0]         s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [31:0]                   s_axil_wdata,
  input  logic [3:0]                    s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]         s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [31:0]                   s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]           reg_update,
  input  logic [31:0]                   status_in
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam logic [IW-1:0] COMMIT_IDX = IW'(NUM_REGS);
  localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS + 1);
  logic                                rdy_q;
  logic                                aw_full_q, w_full_q;
  logic [IW-1:0]                       aw_idx_q;
  logic [31:0]                         w_data_q;
  logic [3:0]                          w_strb_q;
  logic                                bvalid_q, rvalid_q;
  logic [1:0]                          bresp_q, rresp_q;
  logic [31:0]                         rdata_q;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs_q, regs_d, view;
  logic [NUM_REGS-1:0]                 upd_q, upd_d;
  logic                                wr_ok, exec, aw_hs, w_hs, ar_hs;
  logic [IW-1:0]                       ar_idx;
  logic [31:0]                         rd_data;
  logic [1:0]                          rd_resp;
  logic                                unused_lsbs;
`ifdef AXIL_REG_SHADOW_EN
  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  shadow_q, shadow_d;
  assign view = shadow_q;
`else
  assign view = regs_q;
`endif
  function automatic logic [REG_WIDTH-1:0] merge(input logic [REG_WIDTH-1:0] old,
                                                 input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] m;
    m = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return REG_WIDTH'((32'(old) & ~m) | (data & m));
  endfunction
  // Holders may refill in the cycle the pending response is being accepted, giving one write per 2 cycles.
  assign s_axil_awready = rdy_q & ~aw_full_q & (~bvalid_q | s_axil_bready);
  assign s_axil_wready  = rdy_q & ~w_full_q & (~bvalid_q | s_axil_bready);
  assign s_axil_arready = rdy_q & ~rvalid_q;
  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;
  assign exec  = aw_full_q & w_full_q & ~bvalid_q;
  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];
  assign unused_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
  always_comb begin
    regs_d = regs_q;
    upd_d  = '0;
    wr_ok  = (aw_idx_q == COMMIT_IDX);
`ifdef AXIL_REG_SHADOW_EN
    shadow_d = shadow_q;
    for (int i = 0; i < NUM_REGS; i++)
      if (aw_idx_q == IW'(i)) begin
        wr_ok = 1'b1;
        if (exec) shadow_d[i] = merge(shadow_q[i], w_data_q, w_strb_q);
      end
    if (exec && aw_idx_q == COMMIT_IDX) begin
      regs_d = shadow_q;
      upd_d  = '1;
    end
`else
    for (int i = 0; i < NUM_REGS; i++)
      if (aw_idx_q == IW'(i)) begin
        wr_ok = 1'b1;
        if (exec) begin
          regs_d[i] = merge(regs_q[i], w_data_q, w_strb_q);
          upd_d[i]  = 1'b1;
        end
      end
`endif
  end
  always_comb begin
    rd_data = '0;
    rd_resp = (ar_idx == COMMIT_IDX) ? 2'b00 : 2'b10;
    if (ar_idx == STATUS_IDX) begin
      rd_data = status_in;
      rd_resp = 2'b00;
    end
    for (int i = 0; i < NUM_REGS; i++)
      if (ar_idx == IW'(i)) begin
        rd_data = 32'(view[i]);
        rd_resp = 2'b00;
      end
  end
  always_ff @(posedge aclk) begin
    if (arst) begin
      rdy_q     <= 1'b0;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      regs_q    <= {NUM_REGS{REG_WIDTH'(RESET_VAL)}};
      upd_q     <= '0;
`ifdef AXIL_REG_SHADOW_EN
      shadow_q  <= {NUM_REGS{REG_WIDTH'(RESET_VAL)}};
`endif
    end else begin
      rdy_q <= 1'b1;
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axil_awaddr[ADDR_WIDTH-1:2];
      end else if (exec) aw_full_q <= 1'b0;
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axil_wdata;
        w_strb_q <= s_axil_wstrb;
      end else if (exec) w_full_q <= 1'b0;
      regs_q <= regs_d;
      upd_q  <= upd_d;
`ifdef AXIL_REG_SHADOW_EN
      shadow_q <= shadow_d;
`endif
      if (exec) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? 2'b00 : 2'b10;
      end else if (s_axil_bready) bvalid_q <= 1'b0;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (s_axil_rready) rvalid_q <= 1'b0;
    end
  end
  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;
  assign reg_out       = regs_q;
  assign reg_update    = upd_q;
endmodule

// File: doc/axil_reg_bank.md
# axil_reg_bank

Parametrised AXI4-Lite slave register bank exposing NUM_REGS independently addressable, byte-strobed control registers as flat outputs with per-register update pulses, plus read-back of all registers and one read-only status word. Generalises the single data/address JTAG-to-AXI-Lite endpoint: it sits behind the JTAG-AXI master, or any AXI-Lite master, and drives DAC/modulator control fields.

## Interface
- NUM_REGS, 4, number of read/write registers (1..16)
- REG_WIDTH, 8, width of each register (1..32)
- ADDR_WIDTH, 32, AXI address width
- RESET_VAL, 0, reset value of every register (low REG_WIDTH bits used)
- aclk  in  1  clock; all logic rising-edge
- arst  in  1  synchronous, active-high reset
- s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response
- s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
- reg_out  out  NUM_REGS*REG_WIDTH  register i at bits [i*REG_WIDTH +: REG_WIDTH]
- reg_update  out  NUM_REGS  one-cycle pulse per register whose visible value was written
- status_in  in  32  read-only status word

## Operation
- Address map (byte offsets, bits [1:0] ignored): reg i at 4*i; COMMIT at 4*NUM_REGS (write-only, reads 0); STATUS at 4*NUM_REGS+4 (read-only, returns status_in). Any other offset: decode error.
- Write path: AW and W captured independently into one-entry holding registers; awready high while AW holder empty and no B pending; same for wready. Either may arrive first or together.
- When both holders full: perform write, clear holders, raise bvalid. Byte lane k of wstrb updates bits [8k+7:8k] of the register, clipped to REG_WIDTH; wstrb=0 writes nothing but still responds OKAY and pulses reg_update.
- bresp: OKAY (00) for reg/COMMIT; SLVERR (10) for STATUS or unmapped (no state change, no pulse).
- Read path: arready high when rvalid low; on AR handshake, rdata = zero-extended register / status_in / 0, rresp OKAY, or SLVERR with rdata 0 for unmapped.
- Read and write channels operate concurrently; a read accepted on the same edge a write executes returns the pre-write value.

## Timing
- Reset: awready, wready, bvalid, arready, rvalid low in reset cycle; bresp, rresp, rdata 0; all registers RESET_VAL; reg_update 0. awready/wready/arready go high the first cycle after arst deasserts.
- Write latency: write executes on the edge after the later of AW/W handshakes; bvalid and reg_update[i] go high on that same edge; reg_out changes on that edge.
- bvalid held until bready; next write cannot execute while bvalid high (holders may fill). Back-to-back with bready tied high: one write per 2 cycles.
- Read latency: rvalid one cycle after AR handshake; rdata/rresp stable until rready; with rready high, one read per 2 cycles.
- arst mid-transaction: all pending AW/W/B/R state discarded, outputs to reset values next edge.

## Configuration
- AXIL_REG_SHADOW_EN defined: writes to reg i land in shadow register i (read-back returns shadow), no reg_update pulse; a write to COMMIT copies all shadows to reg_out simultaneously and pulses reg_update for every register in the same cycle as bvalid.
- Undefined: no shadow storage; writes take effect directly as above; COMMIT write is OKAY and a no-op.

## Test plan
- Reset: hold arst 3 cycles -> reg_out all RESET_VAL, bvalid=rvalid=0, readies high cycle after release.
- Write 0x5A to offset 0x4 (wstrb=0xF), W one cycle before AW -> reg_out[15:8]=0x5A, reg_update=0b0010 one cycle with bvalid, bresp=00; read 0x4 -> rdata=0x5A.
- Write 0x1234 to offset 0x0 with REG_WIDTH=16, wstrb=0x2 over 0xFFFF -> register 0x12FF.
- Write to 0x40 and read 0x44 (NUM_REGS=4 -> unmapped) -> bresp=10, rresp=10, rdata=0, no reg change; read 0x14 -> status_in value, OKAY.
- bready held low 5 cycles after write -> bvalid stays high, second write not applied until bready handshake.
- With AXIL_REG_SHADOW_EN: write 0x11 to reg0, 0x22 to reg1 -> reg_out unchanged, read-back 0x11/0x22; write COMMIT -> both update same cycle, reg_update=0b1111.
